// File: rtl/array_proc_pkg.sv
// Shared parameter defaults, mode encoding and pointer-width helper for the
// array processing blocks.
package array_proc_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned SUM_W_DEF  = 16;

    typedef enum logic {
        MODE_CUM = 1'b0,
        MODE_WIN = 1'b1
    } mode_e;

    // Address bits needed to index a buffer of the given depth (minimum 1).
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/array_sample_ram.sv
// Sample buffer: one write port, a combinational eviction read at the write
// slot, and a registered readback port.
module array_sample_ram
    import array_proc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ptr_width(DEPTH_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] ev_addr,
    output logic [DATA_W-1:0] ev_data_c,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset; stale entries are never evicted
    // before the window fills.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign ev_data_c = mem[ev_addr];

    // Readback samples pre-write content when reading the slot being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/array_window_accum.sv
// Streaming accumulator producing either a cumulative sum or a sliding-window
// sum over the last DEPTH samples, with a buffer readback port.
module array_window_accum
    import array_proc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned SUM_W  = SUM_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SUM_W-1:0]           out_sum,
    output logic [ptr_width(DEPTH):0]  count,
    output logic                       full,
    output logic                       overflow,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_X = SUM_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [SUM_W-1:0]  cum_sum;
    logic [SUM_W-1:0]  win_sum;
    logic              accept_c;
    logic [DATA_W-1:0] evict_c;
    logic [SUM_X-1:0]  cum_ext_c;
    logic [SUM_W-1:0]  win_next_c;
    logic [CNT_W-1:0]  count_next_c;

    assign in_ready = (!out_valid || out_ready) && !clear;
    assign accept_c = in_valid && in_ready;

    array_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept_c),
        .wr_addr   (wr_ptr),
        .wr_data   (in_data),
        .ev_addr   (wr_ptr),
        .ev_data_c (evict_c),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Post-accept accumulator and count values; the extra cum bit flags a wrap.
    always_comb begin
        cum_ext_c    = '0;
        win_next_c   = '0;
        count_next_c = '0;
        cum_ext_c    = {1'b0, cum_sum} + SUM_X'(in_data);
        win_next_c   = win_sum + SUM_W'(in_data) - (full ? SUM_W'(evict_c) : SUM_W'(0));
        count_next_c = full ? count : count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            cum_sum   <= '0;
            win_sum   <= '0;
            overflow  <= 1'b0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            cum_sum   <= '0;
            win_sum   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept_c) begin
            wr_ptr    <= wr_ptr + PTR_W'(1);
            count     <= count_next_c;
            full      <= (count_next_c == CNT_W'(DEPTH));
            cum_sum   <= cum_ext_c[SUM_W-1:0];
            win_sum   <= win_next_c;
            if (cum_ext_c[SUM_W]) begin
                overflow <= 1'b1;
            end
            // Mode is captured here so later mode changes never alter this result.
            out_sum   <= (mode_e'(mode) == MODE_WIN) ? win_next_c : cum_ext_c[SUM_W-1:0];
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/array_window_accum.md
ARRAY_WINDOW_ACCUM -- requirements
Module: array_window_accum

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits.
REQ-002 Parameter DEPTH, default 8: buffer entries; power of two, at least 2.
REQ-003 Parameter SUM_W, default 16: accumulator width; at least DATA_W + log2(DEPTH).
REQ-004 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset; asynchronous, active-high.
REQ-006 Port clear, input, 1: synchronous flush of accumulators, pointer and count.
REQ-007 Port mode, input, 1: output select; 0 = cumulative sum, 1 = sliding-window sum over the last DEPTH samples.
REQ-008 Ports in_valid (input, 1), in_ready (output, 1), in_data (input, DATA_W): sample input handshake.
REQ-009 Ports out_valid (output, 1), out_ready (input, 1), out_sum (output, SUM_W): result output handshake.
REQ-010 Port count, output, log2(DEPTH)+1: number of samples in the window, 0..DEPTH.
REQ-011 Ports full (output, 1) and overflow (output, 1): full means count equals DEPTH; overflow is the sticky cumulative-wrap flag.
REQ-012 Ports rd_addr (input, log2(DEPTH)) and rd_data (output, DATA_W): buffer readback port.

Function
REQ-013 in_ready SHALL equal (!out_valid || out_ready) && !clear.
REQ-014 A sample is accepted when in_valid && in_ready; in_data is written to buf[wr_ptr].
REQ-015 On accept, wr_ptr SHALL increment modulo DEPTH, and count SHALL increment, saturating at DEPTH.
REQ-016 On accept, cum_sum <= cum_sum + in_data, modulo 2^SUM_W; on wrap, overflow SHALL set and stay set.
REQ-017 On accept, win_sum <= win_sum + in_data - (full ? buf[wr_ptr] : 0); the evicted value is the pre-write content of the slot.
REQ-018 win_sum SHALL never wrap under the REQ-003 constraint.
REQ-019 Both accumulators SHALL update on every accept regardless of mode.
REQ-020 mode SHALL be sampled at accept; out_sum loads the selected post-update sum one cycle after the accept edge.
REQ-021 out_valid SHALL rise the cycle after an accept and fall on out_valid && out_ready unless a new accept occurs in the same cycle.
REQ-022 out_sum SHALL hold stable while out_valid && !out_ready.
REQ-023 Throughput SHALL be one sample per cycle while out_ready is high.
REQ-024 A mode change SHALL affect only results of later accepts; results already presented are not recomputed.
REQ-025 rd_data SHALL equal buf[rd_addr] registered, 1-cycle latency.
REQ-026 A readback of the slot written in the same cycle SHALL return the old content.
REQ-027 clear SHALL zero cum_sum, win_sum, wr_ptr, count, overflow and out_valid next cycle.
REQ-028 clear SHALL leave buffer contents unchanged.
REQ-029 in_valid during a clear cycle SHALL not be accepted.

Reset
REQ-030 rst SHALL asynchronously zero wr_ptr, count, cum_sum, win_sum, out_sum, out_valid, overflow and rd_data.
REQ-031 in_ready SHALL be 1 while rst is low after reset.
REQ-032 Buffer contents after reset are undefined and SHALL never affect outputs, since eviction is gated by full.
REQ-033 Reset asserted mid-stream SHALL discard the in-flight result with no out_valid pulse.

Structure
REQ-034 Package array_proc_pkg SHALL hold the parameter defaults, the mode encoding (MODE_CUM = 0, MODE_WIN = 1) and a function computing pointer width.
REQ-035 Sub-module array_sample_ram SHALL implement the DEPTH x DATA_W buffer with one write port, one combinational eviction read and one registered readback.
REQ-036 Control and accumulators SHALL stay in the top level.

Verification (DATA_W=8, DEPTH=4, SUM_W=10)
REQ-037 mode=1, feed 1,2,3,4,5,6 with out_ready=1 -> out_sum 1,3,6,10,14,18; count 1,2,3,4,4,4; full from the 4th sample on.
REQ-038 mode=0, feed 0xFF x5 -> out_sum 255,510,765,1020,251; overflow set at the 5th result and remains 1.
REQ-039 out_ready=0, in_valid held high with data 7 -> one accept, then in_ready=0; out_sum=7 held; raising out_ready resumes one accept per cycle.
REQ-040 Feed 9,8,7 then clear with in_valid=1 -> sample dropped; count=0, out_valid=0; next sample 2 gives out_sum=2 in both modes.
REQ-041 Feed 10,20,30,40,50 then rd_addr=0..3 -> rd_data 50,20,30,40, each one cycle after its address.
REQ-042 Assert rst mid-stream after 3 accepts -> all outputs 0 immediately; first post-reset sample 5 gives out_sum=5.
